// File: rtl/negedge_reg_pipe_pkg.sv
// rtl/negedge_reg_pipe_pkg.sv - shared defaults and scan-chain length for the falling-edge register pipe
package negedge_reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Every stage contributes its data bits plus its valid bit to the scan chain.
    function automatic int chain_len(input int depth, input int width);
        return depth * (width + 1);
    endfunction

endpackage

// File: rtl/negedge_reg_pipe_if.sv
// rtl/negedge_reg_pipe_if.sv - functional and scan signal bundle for the falling-edge register pipe
interface negedge_reg_pipe_if
    import negedge_reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             EN;
    logic             FLUSH;
    logic             VALID_IN;
    logic [WIDTH-1:0] D;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;
    logic             VALID_OUT;
    logic             SO;

    modport master (
        output EN, FLUSH, VALID_IN, D, SE, SI,
        input  Q, QN, VALID_OUT, SO
    );

    modport slave (
        input  EN, FLUSH, VALID_IN, D, SE, SI,
        output Q, QN, VALID_OUT, SO
    );

endinterface

// File: rtl/negedge_reg_pipe_stage.sv
// rtl/negedge_reg_pipe_stage.sv - one falling-edge data+valid stage with scan mux
module negedge_reg_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             se,
    input  logic             si,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_in,
    output logic [WIDTH-1:0] q,
    output logic             valid_q
);

    // In scan mode the stage is a WIDTH+1 shift register: si enters data bit 0,
    // data bit WIDTH-1 moves into valid, and valid feeds the next stage.
    always_ff @(negedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            q       <= RESET_VAL;
            valid_q <= 1'b0;
        end else if (se) begin
            {valid_q, q} <= {q, si};
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            q       <= d;
            valid_q <= valid_in;
        end
    end

endmodule

// File: rtl/negedge_reg_pipe.sv
// rtl/negedge_reg_pipe.sv - DEPTH-stage falling-edge register pipeline with flush and scan chain
module negedge_reg_pipe
    import negedge_reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    negedge_reg_pipe_if.slave    bus
);

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [WIDTH-1:0] dat [DEPTH+1];
    logic [DEPTH:0]   vld;
    logic [DEPTH-1:0] scan_in;

    assign dat[0] = bus.D;
    assign vld[0] = bus.VALID_IN;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign scan_in[k] = bus.SI;
        end else begin : g_link
            assign scan_in[k] = vld[k];
        end

        negedge_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK      (CLK),
            .RSTB     (RSTB),
            .se       (bus.SE),
            .si       (scan_in[k]),
            .flush    (bus.FLUSH),
            .en       (bus.EN),
            .d        (dat[k]),
            .valid_in (vld[k]),
            .q        (dat[k+1]),
            .valid_q  (vld[k+1])
        );
    end

    assign bus.Q         = dat[DEPTH];
    assign bus.QN        = ~dat[DEPTH];
    assign bus.VALID_OUT = vld[DEPTH];
    assign bus.SO        = vld[DEPTH];

endmodule

// File: tb/tb_negedge_reg_pipe.sv
// tb/tb_negedge_reg_pipe.sv - self-checking bench for negedge_reg_pipe
module tb_negedge_reg_pipe;

    logic CLK  = 1'b1;
    logic RSTB = 1'b1;
    always #5 CLK = ~CLK;

    negedge_reg_pipe_if #(.WIDTH(8)) ifa ();
    negedge_reg_pipe_if #(.WIDTH(4)) ifb ();

    negedge_reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_a (
        .CLK (CLK), .RSTB (RSTB), .bus (ifa)
    );
    negedge_reg_pipe #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'h6)) u_b (
        .CLK (CLK), .RSTB (RSTB), .bus (ifb)
    );

    localparam int CHAIN_B = negedge_reg_pipe_pkg::chain_len(2, 4);

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Model: per-DUT array of stage records; model 0 = ifa, model 1 = ifb.
    logic [63:0] mdata [2][16];
    bit          mval  [2][16];
    int          mw    [2] = '{8, 4};
    int          md    [2] = '{3, 2};
    logic [63:0] mrst  [2] = '{64'hA5, 64'h6};
    logic [63:0] mmask [2] = '{64'hFF, 64'hF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int m);
        for (int k = 0; k < 16; k++) begin
            mdata[m][k] = mrst[m];
            mval[m][k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input bit en, input bit flush, input bit vin,
                              input bit se, input bit si, input logic [63:0] d);
        bit chain [$];
        if (se) begin
            for (int k = 0; k < md[m]; k++) begin
                for (int b = 0; b < mw[m]; b++) chain.push_back(mdata[m][k][b]);
                chain.push_back(mval[m][k]);
            end
            chain.push_front(si);
            void'(chain.pop_back());
            for (int k = 0; k < md[m]; k++) begin
                for (int b = 0; b < mw[m]; b++) mdata[m][k][b] = chain.pop_front();
                mval[m][k] = chain.pop_front();
            end
        end else if (flush) begin
            for (int k = 0; k < md[m]; k++) mval[m][k] = 1'b0;
        end else if (en) begin
            for (int k = md[m] - 1; k > 0; k--) begin
                mdata[m][k] = mdata[m][k-1];
                mval[m][k]  = mval[m][k-1];
            end
            mdata[m][0] = d & mmask[m];
            mval[m][0]  = vin;
        end
    endtask

    function automatic logic [63:0] exp_q(input int m);
        return mdata[m][md[m]-1];
    endfunction

    function automatic logic [63:0] exp_v(input int m);
        return 64'(mval[m][md[m]-1]);
    endfunction

    always @(negedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, ifa.EN, ifa.FLUSH, ifa.VALID_IN, ifa.SE, ifa.SI, 64'(ifa.D));
            model_step(1, ifb.EN, ifb.FLUSH, ifb.VALID_IN, ifb.SE, ifb.SI, 64'(ifb.D));
        end
    end

    always @(posedge CLK) begin
        if (chk_on) begin
            check("a_q",  64'(ifa.Q),         exp_q(0));
            check("a_qn", 64'(ifa.QN),        ~exp_q(0) & 64'hFF);
            check("a_vo", 64'(ifa.VALID_OUT), exp_v(0));
            check("a_so", 64'(ifa.SO),        exp_v(0));
            check("b_q",  64'(ifb.Q),         exp_q(1));
            check("b_qn", 64'(ifb.QN),        ~exp_q(1) & 64'hF);
            check("b_vo", 64'(ifb.VALID_OUT), exp_v(1));
            check("b_so", 64'(ifb.SO),        exp_v(1));
        end
    end

    task automatic edge_wait();
        @(negedge CLK);
        #2;
    endtask

    initial begin
        logic [9:0] pat;
        ifa.EN = 0; ifa.FLUSH = 0; ifa.VALID_IN = 0; ifa.D = '0; ifa.SE = 0; ifa.SI = 0;
        ifb.EN = 0; ifb.FLUSH = 0; ifb.VALID_IN = 0; ifb.D = '0; ifb.SE = 0; ifb.SI = 0;

        // Reset takes effect between edges, without a clock edge.
        #2 RSTB = 1'b0;
        #1;
        check("rst_q",  64'(ifa.Q),         64'hA5);
        check("rst_qn", 64'(ifa.QN),        64'h5A);
        check("rst_vo", 64'(ifa.VALID_OUT), 64'h0);
        check("rst_so", 64'(ifa.SO),        64'h0);
        check("rst_bq", 64'(ifb.Q),         64'h6);
        chk_on = 1'b1;

        ifa.EN = 1; ifa.D = 8'hFF; ifa.VALID_IN = 1;
        repeat (2) edge_wait();
        check("rst_hold_q",  64'(ifa.Q),         64'hA5);
        check("rst_hold_vo", 64'(ifa.VALID_OUT), 64'h0);
        RSTB = 1'b1;

        // Latency of DEPTH=3 falling edges.
        ifa.D = 8'h11; edge_wait();
        check("lat1_q",  64'(ifa.Q),         64'hA5);
        check("lat1_vo", 64'(ifa.VALID_OUT), 64'h0);
        ifa.D = 8'h22; edge_wait();
        check("lat2_vo", 64'(ifa.VALID_OUT), 64'h0);
        ifa.D = 8'h33; edge_wait();
        check("lat3_q",  64'(ifa.Q),         64'h11);
        check("lat3_vo", 64'(ifa.VALID_OUT), 64'h1);
        @(posedge CLK); #1;
        check("rise_q", 64'(ifa.Q), 64'h11);

        // Stall then flush.
        ifa.EN = 0; ifa.D = 8'h44;
        repeat (2) edge_wait();
        check("stall_q",  64'(ifa.Q),         64'h11);
        check("stall_vo", 64'(ifa.VALID_OUT), 64'h1);
        ifa.FLUSH = 1; ifa.EN = 1; ifa.D = 8'h55;
        edge_wait();
        check("flush_vo", 64'(ifa.VALID_OUT), 64'h0);
        check("flush_q",  64'(ifa.Q),         64'h11);
        ifa.FLUSH = 0; ifa.EN = 0;

        // Scan on the 4x2 instance: shift in MSB first, read back in order on SO.
        pat = 10'b1011001110;
        ifb.SE = 1;
        for (int i = 0; i < CHAIN_B; i++) begin
            ifb.SI = pat[CHAIN_B-1-i];
            ifb.EN = 1'($urandom); ifb.FLUSH = 1'($urandom); ifb.D = 4'($urandom);
            ifb.VALID_IN = 1'($urandom);
            edge_wait();
        end
        for (int i = 0; i < CHAIN_B; i++) begin
            check("scan_so", 64'(ifb.SO), 64'(pat[CHAIN_B-1-i]));
            ifb.SI = 0;
            ifb.EN = 1'($urandom); ifb.FLUSH = 1'($urandom);
            edge_wait();
        end
        ifb.SE = 0; ifb.EN = 0; ifb.FLUSH = 0;

        // Async reset in the middle of a scan on the 8x3 instance.
        ifa.SE = 1;
        repeat (5) begin
            ifa.SI = 1'($urandom);
            edge_wait();
        end
        RSTB = 1'b0;
        #1;
        check("mid_scan_q",  64'(ifa.Q),         64'hA5);
        check("mid_scan_vo", 64'(ifa.VALID_OUT), 64'h0);
        check("mid_scan_so", 64'(ifa.SO),        64'h0);
        check("mid_scan_bq", 64'(ifb.Q),         64'h6);
        #1 RSTB = 1'b1;
        ifa.SE = 0; ifa.EN = 1; ifa.D = 8'h77; ifa.VALID_IN = 1;
        edge_wait();
        ifa.D = 8'h88; ifa.VALID_IN = 0;
        edge_wait();
        check("post_rst_q2",  64'(ifa.Q),         64'hA5);
        check("post_rst_vo2", 64'(ifa.VALID_OUT), 64'h0);
        edge_wait();
        check("post_rst_q3",  64'(ifa.Q),         64'h77);
        check("post_rst_vo3", 64'(ifa.VALID_OUT), 64'h1);

        // Randomized traffic on both instances, with occasional reset pulses.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(63) == 0) begin
                RSTB = 1'b0;
                #1 RSTB = 1'b1;
            end
            ifa.SE = ($urandom_range(7) == 0); ifa.SI = 1'($urandom);
            ifa.FLUSH = ($urandom_range(7) == 0); ifa.EN = ($urandom_range(3) != 0);
            ifa.VALID_IN = 1'($urandom); ifa.D = 8'($urandom);
            ifb.SE = ($urandom_range(7) == 0); ifb.SI = 1'($urandom);
            ifb.FLUSH = ($urandom_range(7) == 0); ifb.EN = ($urandom_range(3) != 0);
            ifb.VALID_IN = 1'($urandom); ifb.D = 4'($urandom);
            edge_wait();
        end

        @(posedge CLK); #1;
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/negedge_reg_pipe.md
NEGEDGE_REG_PIPE -- requirements
Module: negedge_reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (1..64).
REQ-002 Parameter DEPTH, default 2, number of pipeline stages (1..16).
REQ-003 Parameter RESET_VAL, default all-zeros, WIDTH-bit data value loaded on reset.
REQ-004 CLK  input  1  clock; all state updates on the falling edge.
REQ-005 RSTB  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  advance enable for functional mode.
REQ-007 FLUSH  input  1  synchronous clear of all valid bits.
REQ-008 VALID_IN  input  1  qualifies D.
REQ-009 D  input  WIDTH  data into stage 0.
REQ-010 SE  input  1  scan enable.
REQ-011 SI  input  1  scan serial input.
REQ-012 Q  output  WIDTH  data of the last stage.
REQ-013 QN  output  WIDTH  bitwise complement of Q.
REQ-014 VALID_OUT  output  1  valid bit of the last stage.
REQ-015 SO  output  1  scan serial output.

Function
REQ-016 Each stage k SHALL hold a WIDTH-bit data register and a 1-bit valid register, both updated only on the falling edge of CLK or asynchronously by RSTB.
REQ-017 Per-edge priority SHALL be: RSTB low, then SE, then FLUSH, then EN, otherwise hold.
REQ-018 Functional advance (SE=0, FLUSH=0, EN=1): stage 0 <= {D, VALID_IN}; stage k <= stage k-1 for k=1..DEPTH-1.
REQ-019 Latency from D/VALID_IN sampled to Q/VALID_OUT SHALL be exactly DEPTH falling edges with EN high; edges with EN=0 SHALL hold all stages.
REQ-020 Data SHALL advance regardless of valid state; invalid entries SHALL still shift.
REQ-021 FLUSH=1 (SE=0) SHALL clear every valid bit on that edge, leave all data registers unchanged, and SHALL ignore EN and VALID_IN.
REQ-022 Scan shift (SE=1) SHALL treat all registers as one chain of length DEPTH*(WIDTH+1), ignoring EN, FLUSH, D and VALID_IN.
REQ-023 Chain order SHALL be SI -> stage0 data bit 0 -> ... -> stage0 data bit WIDTH-1 -> stage0 valid -> stage1 data bit 0 -> ... -> stage DEPTH-1 valid -> SO.
REQ-024 SO SHALL equal the last-stage valid register (combinational from the flop, no extra stage).
REQ-025 QN SHALL be combinationally derived from Q, never a separate register.
REQ-026 DEPTH=1 SHALL be legal and give a single-edge latency with a WIDTH+1 chain.

Reset
REQ-027 RSTB low SHALL immediately, without a clock edge, force all data registers to RESET_VAL and all valid registers to 0; then Q=RESET_VAL, QN=~RESET_VAL, VALID_OUT=0, SO=0.
REQ-028 While RSTB is low, clock edges SHALL have no effect.
REQ-029 RSTB rising SHALL be synchronous to the falling edge of CLK (recovery/removal checked against the falling edge); the first falling edge after release SHALL perform a normal update.
REQ-030 Reset asserted mid-operation or mid-scan SHALL discard all pipeline contents, with no partial shift.

Structure
REQ-031 A shared package SHALL hold default parameter values and the scan-chain length function DEPTH*(WIDTH+1); no typedefs needed.
REQ-032 One sub-module negedge_reg_stage (WIDTH-bit data plus valid, falling-edge, async active-low reset, scan mux) SHALL be instantiated DEPTH times via generate.
REQ-033 No latches; no logic on the clock or reset path.

Verification
REQ-034 Reset: RSTB=0 between edges, RESET_VAL=8'hA5 -> Q=8'hA5, QN=8'h5A, VALID_OUT=0 immediately, no CLK edge needed.
REQ-035 Latency: DEPTH=3, EN=1, D=8'h11,8'h22,8'h33 with VALID_IN=1 on successive falling edges -> Q=8'h11, VALID_OUT=1 after the 3rd falling edge; no change on rising edges.
REQ-036 Stall/flush: EN=0 for 2 edges -> Q held; then FLUSH=1 with EN=1 for one edge -> VALID_OUT=0, Q unchanged.
REQ-037 Scan: WIDTH=4, DEPTH=2, SE=1, shift in a 10-bit pattern 10'b1011001110 -> read back in order on SO after 10 more edges; EN and FLUSH toggling have no effect.
REQ-038 Async reset mid-scan: RSTB low after 5 scan edges -> all state = reset values; after release, the next falling edge with SE=0, EN=1 loads D into stage 0.
